// File: rtl/diff_addmul_pkg.sv
// diff_addmul_pkg: shared state encodings, opcodes and the abs-difference helper.
package diff_addmul_pkg;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DIFF = 3'd1;
    localparam logic [2:0] S_ADD  = 3'd2;
    localparam logic [2:0] S_M_AC = 3'd3;
    localparam logic [2:0] S_M_AD = 3'd4;
    localparam logic [2:0] S_M_BC = 3'd5;
    localparam logic [2:0] S_OUT  = 3'd6;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_MUL = 1'b0;

    function automatic logic [7:0] abs_diff(input logic [7:0] x, input logic [7:0] y);
        logic [8:0] d;
        d = {1'b0, x} - {1'b0, y};
        return d[8] ? 8'h00 - d[7:0] : d[7:0];
    endfunction
endpackage

// File: rtl/diff_addmul_ctrl_if.sv
// diff_addmul_ctrl_if: job input and result output handshakes of the diff/add/mul controller.
interface diff_addmul_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] i;
    logic [7:0] j;
    logic [7:0] k;
    logic       operation;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] vo;

    modport master (output in_valid, i, j, k, operation, out_ready,
                    input  in_ready, out_valid, vo);
    modport slave  (input  in_valid, i, j, k, operation, out_ready,
                    output in_ready, out_valid, vo);
endinterface

// File: rtl/nib_mul4.sv
// nib_mul4: 4x4 -> 8-bit unsigned combinational multiplier.
module nib_mul4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    assign p = {4'h0, x} * {4'h0, y};
endmodule

// File: rtl/diff_addmul_ctrl.sv
// diff_addmul_ctrl: sequences |i-j| then +k or *k (mod 256) through one shared nibble multiplier.
module diff_addmul_ctrl
    import diff_addmul_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    diff_addmul_ctrl_if.slave  bus,
    output logic               busy,
    output logic [CNT_W-1:0]   done_cnt
);
    logic [2:0] state, nxt;
    logic       op_r;
    logic [7:0] i_r, j_r, k_r, abs_r, acc, acc_nxt, prod;
    logic [3:0] mx, my;
    logic       skip_ad, skip_bc, out_fire;

    assign skip_ad  = SKIP_ZERO && (abs_r[3:0] == 4'h0 || k_r[7:4] == 4'h0);
    assign skip_bc  = SKIP_ZERO && (abs_r[7:4] == 4'h0 || k_r[3:0] == 4'h0);
    assign mx       = state == S_M_BC ? abs_r[7:4] : abs_r[3:0];
    assign my       = state == S_M_AD ? k_r[7:4] : k_r[3:0];
    assign out_fire = state == S_OUT && bus.out_ready;

    nib_mul4 u_mul (.x(mx), .y(my), .p(prod));

    always_comb begin
        nxt = S_IDLE;
        case (state)
            S_IDLE:  nxt = bus.in_valid ? S_DIFF : S_IDLE;
            S_DIFF:  nxt = op_r == OP_ADD ? S_ADD : S_M_AC;
            S_ADD:   nxt = S_OUT;
            S_M_AC:  nxt = !skip_ad ? S_M_AD : !skip_bc ? S_M_BC : S_OUT;
            S_M_AD:  nxt = skip_bc ? S_OUT : S_M_BC;
            S_M_BC:  nxt = S_OUT;
            S_OUT:   nxt = bus.out_ready ? S_IDLE : S_OUT;
            default: nxt = S_IDLE;
        endcase
    end

    // Cross terms land at bit 4; only their low nibble survives mod 256.
    always_comb begin
        acc_nxt = state == S_ADD  ? abs_r + k_r :
                  state == S_M_AC ? prod :
                  (state == S_M_AD || state == S_M_BC) ? acc + {prod[3:0], 4'h0} : acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            op_r     <= 1'b0;
            i_r      <= 8'h00;
            j_r      <= 8'h00;
            k_r      <= 8'h00;
            abs_r    <= 8'h00;
            acc      <= 8'h00;
            done_cnt <= '0;
        end else begin
            state <= nxt;
            acc   <= acc_nxt;
            if (state == S_IDLE && bus.in_valid) begin
                i_r  <= bus.i;
                j_r  <= bus.j;
                k_r  <= bus.k;
                op_r <= bus.operation;
            end
            if (state == S_DIFF)
                abs_r <= abs_diff(i_r, j_r);
            if (out_fire)
                done_cnt <= done_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = state == S_IDLE;
    assign bus.out_valid = state == S_OUT;
    assign bus.vo        = acc;
    assign busy          = state != S_IDLE;
endmodule
